// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - shared types for the unified RAM port arbiter
package memory_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } arb_state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - cache and RAM side signals of the arbiter
interface memory_arbiter_if;
    import memory_arbiter_pkg::*;

    // instruction cache
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;
    // data cache
    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dstore;
    logic  dwait;
    word_t dload;
    // RAM
    logic  ramREN;
    logic  ramWEN;
    word_t ramaddr;
    word_t ramstore;
    word_t ramload;
    logic  ram_ready;

    modport arb (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport cache (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  iwait, iload, dwait, dload
    );

    modport ram (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ram_ready
    );

endinterface

// File: rtl/memory_arbiter_starve_ctr.sv
// rtl/memory_arbiter_starve_ctr.sv - saturating count of data wins over a waiting fetch
module memory_arbiter_starve_ctr
    import memory_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign sat = (cnt_q == SAT_VAL);

    // clear has precedence; increments stop once the limit is reached
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // counter register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - grants the single RAM port to the I-cache or D-cache
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    memory_arbiter_if.arb    bus
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       starve_sat;
    logic       d_req;
    logic       starve_inc;
    logic       starve_clr;

    assign d_req      = bus.dREN | bus.dWEN;
    assign starve_inc = (state_q == DSERV) & bus.ram_ready & bus.iREN;
    assign starve_clr = (state_q == ISERV) & bus.ram_ready;

    memory_arbiter_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (starve_inc),
        .clr  (starve_clr),
        .sat  (starve_sat)
    );

    // next grant: completion or withdrawal returns to IDLE; ready wins over withdrawal
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (starve_sat && bus.iREN) begin
                    state_d = ISERV;
                end else if (d_req) begin
                    state_d = DSERV;
                end else if (bus.iREN) begin
                    state_d = ISERV;
                end
            end
            DSERV: begin
                if (bus.ram_ready || !d_req) begin
                    state_d = IDLE;
                end
            end
            ISERV: begin
                if (bus.ram_ready || !bus.iREN) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // grant register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RAM muxing and cache returns; strobes depend only on state and requests, never on ram_ready
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        case (state_q)
            DSERV: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = !bus.dWEN;
                bus.dwait    = !bus.ram_ready;
                bus.dload    = bus.ramload;
            end
            ISERV: begin
                bus.ramaddr  = bus.iaddr;
                bus.ramREN   = 1'b1;
                bus.iwait    = !bus.ram_ready;
                bus.iload    = bus.ramload;
            end
            default: ;
        endcase
    end

endmodule
